// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the 2K x 8 dual-bank memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam int   BANK_AW  = 10;
  localparam int   DATA_W   = 8;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [1:0] onehot_bank(input logic addr_msb);
    return addr_msb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester combinational arbiter; prio picks the winner only on contention.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: rtl/mem2k_arbiter_ctrl.sv
// Setup/access/hold sequencer and round-robin front end for two 1K x 8 async RAM banks.
//   state  | meaning
//   IDLE   | arbitrate, latch grantee address/data/direction
//   SETUP  | bank pins stable, CS low, load access counter
//   ACCESS | CS high for ACC_CYCLES cycles, read captured on last edge
//   HOLD   | CS low with pins held, ack to grantee, rotate priority
module mem2k_arbiter_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ACC_CYCLES = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [DATA_W-1:0]  wdata0,
  output logic               ack0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata1,
  output logic               ack1,
  output logic [DATA_W-1:0]  rdata,
  output logic [BANK_AW-1:0] ram_addr,
  output logic [1:0]         ram_cs,
  output logic               ram_rw,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  localparam logic [3:0] LP_CNT_LOAD = 4'(ACC_CYCLES - 1);

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_prio;
  logic       r_gnt_id;
  logic       r_bank;

  logic [1:0]        w_gnt;
  logic              w_gnt_valid;
  logic              w_sel1;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_acc_last;

  rr_arbiter2 u_arb (
    .req       ({req1, req0}),
    .prio      (r_prio),
    .en        (r_state == IDLE),
    .gnt       (w_gnt),
    .gnt_valid (w_gnt_valid)
  );

  assign w_sel1      = w_gnt[1] & ~w_gnt[0];
  assign w_sel_we    = w_sel1 ? we1    : we0;
  assign w_sel_addr  = w_sel1 ? addr1  : addr0;
  assign w_sel_wdata = w_sel1 ? wdata1 : wdata0;
  assign w_acc_last  = (r_state == ACCESS) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (r_cnt == 4'd0) w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_prio    <= 1'b0;
      r_gnt_id  <= 1'b0;
      r_bank    <= 1'b0;
      ram_cs    <= 2'b00;
      ram_rw    <= RW_READ;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id  <= w_sel1;
            ram_addr  <= w_sel_addr[BANK_AW-1:0];
            r_bank    <= w_sel_addr[ADDR_W-1];
            ram_rw    <= w_sel_we ? RW_WRITE : RW_READ;
            ram_wdata <= w_sel_wdata;
          end
        end
        SETUP: begin
          r_cnt  <= LP_CNT_LOAD;
          ram_cs <= onehot_bank(r_bank);
        end
        ACCESS: begin
          if (w_acc_last) begin
            // CS drops on this edge so HOLD sees pins stable with the bank deselected
            ram_cs <= 2'b00;
            ack0   <= ~r_gnt_id;
            ack1   <= r_gnt_id;
            if (ram_rw == RW_READ) rdata <= ram_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          ram_rw <= RW_READ;
          r_prio <= ~r_gnt_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem2k_arbiter_ctrl.sv
// Directed bench for mem2k_arbiter_ctrl with a two-bank behavioural RAM model.
module tb_mem2k_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_cs;
  logic        ram_rw;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0] bank0 [1024];
  logic [7:0] bank1 [1024];

  int n_chk  = 0;
  int n_pass = 0;

  int         lat, cs_n, ack_n, cs_tot;
  logic [1:0] cs_or, acks;
  logic       rw_cs;

  always #5 clk = ~clk;

  mem2k_arbiter_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rw(ram_rw),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always_comb begin
    ram_rdata = 8'h00;
    if (ram_cs[0]) ram_rdata = ram_rdata | bank0[ram_addr];
    if (ram_cs[1]) ram_rdata = ram_rdata | bank1[ram_addr];
  end

  always @(posedge clk) begin
    if (ram_cs[0] && !ram_rw) bank0[ram_addr] <= ram_wdata;
    if (ram_cs[1] && !ram_rw) bank1[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int lat_o, output int cs_n_o, output logic [1:0] cs_or_o,
                          output logic [1:0] acks_o, output logic rw_cs_o);
    lat_o = 99; cs_n_o = 0; cs_or_o = 2'b00; acks_o = 2'b00; rw_cs_o = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ram_cs != 2'b00) begin
        cs_n_o++;
        cs_or_o = cs_or_o | ram_cs;
        rw_cs_o = ram_rw;
      end
      if (ack0 || ack1) begin
        acks_o = {ack1, ack0};
        lat_o  = i;
        break;
      end
    end
  endtask

  task automatic drive(input int id, input logic we, input logic [10:0] addr, input logic [7:0] wd);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else         begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
  endtask

  task automatic do_req(input int id, input logic we, input logic [10:0] addr, input logic [7:0] wd);
    tick();
    drive(id, we, addr, wd);
    wait_ack(lat, cs_n, cs_or, acks, rw_cs);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic quiet(input int n);
    ack_n = 0; cs_tot = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ack0 || ack1) ack_n++;
      if (ram_cs != 2'b00) cs_tot++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bank0[i] = 8'(i);
      bank1[i] = 8'(i + 8'h80);
    end
    bank0[1]     = 8'h5A;
    bank0[6]     = 8'h33;
    bank0[16]    = 8'h11;
    bank1[32]    = 8'h22;
    bank0[10'h3FF] = 8'h3C;
    bank1[0]     = 8'hC3;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick(); tick();
    chk("rst_cs",    32'(ram_cs),    32'h0);
    chk("rst_rw",    32'(ram_rw),    32'h1);
    chk("rst_addr",  32'(ram_addr),  32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata),     32'h0);
    chk("rst_acks",  32'({ack1, ack0}), 32'h0);
    rst = 1'b0;

    // single read from bank 0
    do_req(0, 1'b0, 11'h001, 8'h00);
    chk("t1_lat",   32'(lat),   32'd4);
    chk("t1_csn",   32'(cs_n),  32'd2);
    chk("t1_cs",    32'(cs_or), 32'h1);
    chk("t1_acks",  32'(acks),  32'h1);
    chk("t1_rdata", 32'(rdata), 32'h5A);

    // write then read back in bank 1
    do_req(1, 1'b1, 11'h406, 8'hAC);
    chk("t2w_lat",  32'(lat),   32'd4);
    chk("t2w_cs",   32'(cs_or), 32'h2);
    chk("t2w_rw",   32'(rw_cs), 32'h0);
    chk("t2w_acks", 32'(acks),  32'h2);
    tick();
    chk("t2_idle_rw",    32'(ram_rw),    32'h1);
    chk("t2_idle_cs",    32'(ram_cs),    32'h0);
    chk("t2_idle_addr",  32'(ram_addr),  32'h006);
    chk("t2_idle_wdata", 32'(ram_wdata), 32'hAC);
    chk("t2_rdata_kept", 32'(rdata),     32'h5A);
    chk("t2_bank1_6",    32'(bank1[6]),  32'hAC);
    chk("t2_bank0_6",    32'(bank0[6]),  32'h33);
    do_req(1, 1'b0, 11'h406, 8'h00);
    chk("t2r_rdata", 32'(rdata), 32'hAC);
    chk("t2r_rw",    32'(rw_cs), 32'h1);

    // contention: both held from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 11'h010, 8'h00);
    drive(1, 1'b0, 11'h420, 8'h00);
    for (int t = 0; t < 4; t++) begin
      wait_ack(lat, cs_n, cs_or, acks, rw_cs);
      chk($sformatf("t3_acks%0d", t),  32'(acks),  (t % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t3_lat%0d", t),   32'(lat),   (t == 0) ? 32'd4 : 32'd5);
      chk($sformatf("t3_rdata%0d", t), 32'(rdata), (t % 2 == 0) ? 32'h11 : 32'h22);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // bank boundary
    do_req(0, 1'b0, 11'h3FF, 8'h00);
    chk("t4a_cs",    32'(cs_or),    32'h1);
    chk("t4a_addr",  32'(ram_addr), 32'h3FF);
    chk("t4a_rdata", 32'(rdata),    32'h3C);
    do_req(0, 1'b0, 11'h400, 8'h00);
    chk("t4b_cs",    32'(cs_or),    32'h2);
    chk("t4b_addr",  32'(ram_addr), 32'h000);
    chk("t4b_rdata", 32'(rdata),    32'hC3);

    // reset in the middle of a write access
    tick();
    drive(0, 1'b1, 11'h055, 8'h99);
    tick();
    tick();
    chk("t5_cs_acc", 32'(ram_cs), 32'h1);
    chk("t5_rw_acc", 32'(ram_rw), 32'h0);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    chk("t5_cs",    32'(ram_cs), 32'h0);
    chk("t5_rw",    32'(ram_rw), 32'h1);
    chk("t5_ack",   32'({ack1, ack0}), 32'h0);
    chk("t5_rdata", 32'(rdata),  32'h0);
    rst = 1'b0;
    quiet(6);
    chk("t5_no_ack", 32'(ack_n),  32'd0);
    chk("t5_no_cs",  32'(cs_tot), 32'd0);
    do_req(1, 1'b0, 11'h406, 8'h00);
    chk("t5_next_lat",   32'(lat),   32'd4);
    chk("t5_next_rdata", 32'(rdata), 32'hAC);

    // request dropped during SETUP still completes once
    tick();
    drive(0, 1'b0, 11'h001, 8'h00);
    tick();
    req0 = 1'b0;
    wait_ack(lat, cs_n, cs_or, acks, rw_cs);
    chk("t6_lat",   32'(lat),   32'd3);
    chk("t6_acks",  32'(acks),  32'h1);
    chk("t6_rdata", 32'(rdata), 32'h5A);
    quiet(8);
    chk("t6_no_ack", 32'(ack_n),  32'd0);
    chk("t6_no_cs",  32'(cs_tot), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
